// File: rtl/dispatch_stage.sv
// dispatch_stage: one-deep registered dispatch between rename and the
// INT / MULT / DIV / LD-ST issue queues. Classifies each instruction,
// resolves operand-ready flags, holds it until its queue has room, and
// serialises behind branches/JALR until they resolve.
module dispatch_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  jmp_br_addr,
    input  logic [TAG_W:0]   rs1_tag,
    input  logic [TAG_W:0]   rs2_tag,
    input  logic [TAG_W-1:0] rd_tag,

    input  logic             int_full,
    input  logic             mult_full,
    input  logic             div_full,
    input  logic             ldst_full,
    input  logic             br_resolve,
    input  logic             flush,

    output logic             int_dispatch_en,
    output logic             mult_dispatch_en,
    output logic             div_dispatch_en,
    output logic             ldst_dispatch_en,

    output logic [6:0]       d_opcode,
    output logic [2:0]       d_func3,
    output logic [6:0]       d_func7,
    output logic [XLEN-1:0]  d_rs1_data,
    output logic [XLEN-1:0]  d_rs2_data,
    output logic [TAG_W-1:0] d_rs1_tag,
    output logic [TAG_W-1:0] d_rs2_tag,
    output logic             d_rs1_valid,
    output logic             d_rs2_valid,
    output logic [TAG_W-1:0] d_rd_tag,
    output logic [XLEN-1:0]  d_imm,
    output logic             illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] MULDIV_F7 = 7'b0000001;

    typedef enum logic [1:0] {
        CLS_INT  = 2'd0,
        CLS_MULT = 2'd1,
        CLS_DIV  = 2'd2,
        CLS_LDST = 2'd3
    } cls_e;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_e;

    // Target queue for an opcode; unknown opcodes fall into INT but are
    // flagged separately and never strobe.
    function automatic cls_e classify(input logic [6:0] opc,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
        cls_e c;
        c = CLS_INT;
        if (opc == OP_R && f7 == MULDIV_F7) begin
            if (f3 < 3'd4) c = CLS_MULT;
            else           c = CLS_DIV;
        end else if (opc == OP_LD || opc == OP_ST) begin
            c = CLS_LDST;
        end
        return c;
    endfunction

    function automatic logic is_known(input logic [6:0] opc);
        logic k;
        case (opc)
            OP_R, OP_I, OP_BR, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_LD, OP_ST: k = 1'b1;
            default:                        k = 1'b0;
        endcase
        return k;
    endfunction

    // Branch and JALR stall later instructions until br_resolve; JAL does not.
    function automatic logic is_serialising(input logic [6:0] opc);
        return (opc == OP_BR) || (opc == OP_JALR);
    endfunction

    // ---- stage p0: decode of the offered instruction ----
    cls_e            cls_p0;
    logic            ill_p0;
    logic            br_p0;
    logic            rs1_valid_p0;
    logic            rs2_valid_p0;
    logic [XLEN-1:0] rs2_data_p0;

    // Classify and resolve operand readiness/substitution before capture.
    always_comb begin
        cls_p0       = classify(opcode, func3, func7);
        ill_p0       = ~is_known(opcode);
        br_p0        = is_serialising(opcode);
        rs1_valid_p0 = (rs1 == '0) | ~rs1_tag[TAG_W];
        rs2_valid_p0 = (rs2 == '0) | ~rs2_tag[TAG_W];
        rs2_data_p0  = rs2_data;
        if (opcode == OP_I) begin
            rs2_data_p0  = immediate;
            rs2_valid_p0 = 1'b1;
        end else if (opcode == OP_LD) begin
            rs2_valid_p0 = 1'b1;
        end
    end

    // ---- stage p1: output register held until the queue accepts ----
    logic             vld_p1;
    cls_e             cls_p1;
    logic             ill_p1;
    logic             br_p1;
    logic [6:0]       opcode_p1;
    logic [2:0]       func3_p1;
    logic [6:0]       func7_p1;
    logic [XLEN-1:0]  rs1_data_p1;
    logic [XLEN-1:0]  rs2_data_p1;
    logic [TAG_W-1:0] rs1_tag_p1;
    logic [TAG_W-1:0] rs2_tag_p1;
    logic             rs1_valid_p1;
    logic             rs2_valid_p1;
    logic [TAG_W-1:0] rd_tag_p1;
    logic [XLEN-1:0]  imm_p1;

    state_e state;
    state_e state_nxt;
    logic   full_sel;
    logic   fire;
    logic   capture;

    // Release logic: the held instruction leaves when its queue has room and
    // no branch is outstanding; illegal ones leave regardless of queue state.
    always_comb begin
        state_nxt        = state;
        full_sel         = 1'b0;
        fire             = 1'b0;
        int_dispatch_en  = 1'b0;
        mult_dispatch_en = 1'b0;
        div_dispatch_en  = 1'b0;
        ldst_dispatch_en = 1'b0;
        illegal          = 1'b0;

        case (cls_p1)
            CLS_INT:  full_sel = int_full;
            CLS_MULT: full_sel = mult_full;
            CLS_DIV:  full_sel = div_full;
            CLS_LDST: full_sel = ldst_full;
            default:  full_sel = 1'b1;
        endcase

        if (vld_p1 && state == RUN && !flush && (ill_p1 || !full_sel))
            fire = 1'b1;

        if (fire && ill_p1) begin
            illegal = 1'b1;
        end else if (fire) begin
            int_dispatch_en  = (cls_p1 == CLS_INT);
            mult_dispatch_en = (cls_p1 == CLS_MULT);
            div_dispatch_en  = (cls_p1 == CLS_DIV);
            ldst_dispatch_en = (cls_p1 == CLS_LDST);
        end

        case (state)
            RUN:     if (fire && !ill_p1 && br_p1) state_nxt = BR_WAIT;
            BR_WAIT: if (br_resolve)               state_nxt = RUN;
            default:                               state_nxt = RUN;
        endcase

        if (flush)
            state_nxt = RUN;
    end

    assign in_ready = rst_n & ~flush & (~vld_p1 | fire);
    assign capture  = in_valid & in_ready;

    // Branch-serialisation state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Occupancy of the output register: set on capture, cleared on release or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            cls_p1 <= CLS_INT;
            ill_p1 <= 1'b0;
            br_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1 <= 1'b1;
            cls_p1 <= cls_p0;
            ill_p1 <= ill_p0;
            br_p1  <= br_p0;
        end else if (fire) begin
            vld_p1 <= 1'b0;
        end
    end

    // Payload register: loaded on capture, otherwise held stable for the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_p1    <= '0;
            func3_p1     <= '0;
            func7_p1     <= '0;
            rs1_data_p1  <= '0;
            rs2_data_p1  <= '0;
            rs1_tag_p1   <= '0;
            rs2_tag_p1   <= '0;
            rs1_valid_p1 <= 1'b0;
            rs2_valid_p1 <= 1'b0;
            rd_tag_p1    <= '0;
            imm_p1       <= '0;
        end else if (capture) begin
            opcode_p1    <= opcode;
            func3_p1     <= func3;
            func7_p1     <= func7;
            rs1_data_p1  <= rs1_data;
            rs2_data_p1  <= rs2_data_p0;
            rs1_tag_p1   <= rs1_tag[TAG_W-1:0];
            rs2_tag_p1   <= rs2_tag[TAG_W-1:0];
            rs1_valid_p1 <= rs1_valid_p0;
            rs2_valid_p1 <= rs2_valid_p0;
            rd_tag_p1    <= rd_tag;
            imm_p1       <= jmp_br_addr;
        end
    end

    assign d_opcode    = opcode_p1;
    assign d_func3     = func3_p1;
    assign d_func7     = func7_p1;
    assign d_rs1_data  = rs1_data_p1;
    assign d_rs2_data  = rs2_data_p1;
    assign d_rs1_tag   = rs1_tag_p1;
    assign d_rs2_tag   = rs2_tag_p1;
    assign d_rs1_valid = rs1_valid_p1;
    assign d_rs2_valid = rs2_valid_p1;
    assign d_rd_tag    = rd_tag_p1;
    assign d_imm       = imm_p1;

endmodule

// File: tb/tb_dispatch_stage.sv
// Scoreboard bench for dispatch_stage: stimulus pushes the expected
// dispatch (class, cycle, payload) and a negedge monitor pops and compares
// whenever any strobe or the illegal pulse is high.
module tb_dispatch_stage;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int REG_W = 5;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [REG_W-1:0] rs1, rs2;
    logic [XLEN-1:0]  rs1_data, rs2_data, immediate, jmp_br_addr;
    logic [TAG_W:0]   rs1_tag, rs2_tag;
    logic [TAG_W-1:0] rd_tag;
    logic             int_full, mult_full, div_full, ldst_full;
    logic             br_resolve, flush;
    logic             int_dispatch_en, mult_dispatch_en, div_dispatch_en, ldst_dispatch_en;
    logic [6:0]       d_opcode;
    logic [2:0]       d_func3;
    logic [6:0]       d_func7;
    logic [XLEN-1:0]  d_rs1_data, d_rs2_data, d_imm;
    logic [TAG_W-1:0] d_rs1_tag, d_rs2_tag, d_rd_tag;
    logic             d_rs1_valid, d_rs2_valid;
    logic             illegal;

    dispatch_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .immediate(immediate), .jmp_br_addr(jmp_br_addr),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rd_tag(rd_tag),
        .int_full(int_full), .mult_full(mult_full),
        .div_full(div_full), .ldst_full(ldst_full),
        .br_resolve(br_resolve), .flush(flush),
        .int_dispatch_en(int_dispatch_en), .mult_dispatch_en(mult_dispatch_en),
        .div_dispatch_en(div_dispatch_en), .ldst_dispatch_en(ldst_dispatch_en),
        .d_opcode(d_opcode), .d_func3(d_func3), .d_func7(d_func7),
        .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
        .d_rs1_tag(d_rs1_tag), .d_rs2_tag(d_rs2_tag),
        .d_rs1_valid(d_rs1_valid), .d_rs2_valid(d_rs2_valid),
        .d_rd_tag(d_rd_tag), .d_imm(d_imm),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 INT, 1 MULT, 2 DIV, 3 LDST, 4 illegal
    typedef struct {
        int          kind;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] rs2d;
        logic        v1;
        logic        v2;
        logic [5:0]  rd;
        logic [31:0] imm;
        logic [5:0]  t1;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] rs2d, input logic v1, input logic v2,
                        input logic [5:0] rd, input logic [31:0] imm,
                        input logic [5:0] t1, input int c);
        exp_t e;
        e.kind = kind; e.opc = opc; e.f3 = f3; e.rs2d = rs2d; e.v1 = v1; e.v2 = v2;
        e.rd = rd; e.imm = imm; e.t1 = t1; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] im, input logic [31:0] addr,
                         input logic [6:0] t1, input logic [6:0] t2, input logic [5:0] rd);
        opcode = opc; func3 = f3; func7 = f7; rs1 = r1; rs2 = r2;
        rs1_data = d1; rs2_data = d2; immediate = im; jmp_br_addr = addr;
        rs1_tag = t1; rs2_tag = t2; rd_tag = rd; in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string name, input logic exp);
        @(negedge clk);
        chk(name, in_ready, exp);
    endtask

    // Monitor: every strobe or illegal pulse must match the next expected dispatch.
    always @(negedge clk) begin
        logic [4:0] v;
        exp_t e;
        v = {illegal, ldst_dispatch_en, div_dispatch_en, mult_dispatch_en, int_dispatch_en};
        if (v != 5'd0) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", v, 5'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind",  v, 5'd1 << e.kind);
                chk("strobe_cycle", cyc, e.cyc);
                chk("d_opcode",     d_opcode, e.opc);
                chk("d_func3",      d_func3, e.f3);
                chk("d_rs2_data",   d_rs2_data, e.rs2d);
                chk("d_rs1_valid",  d_rs1_valid, e.v1);
                chk("d_rs2_valid",  d_rs2_valid, e.v2);
                chk("d_rd_tag",     d_rd_tag, e.rd);
                chk("d_imm",        d_imm, e.imm);
                chk("d_rs1_tag",    d_rs1_tag, e.t1);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        opcode = '0; func3 = '0; func7 = '0; rs1 = '0; rs2 = '0;
        rs1_data = '0; rs2_data = '0; immediate = '0; jmp_br_addr = '0;
        rs1_tag = '0; rs2_tag = '0; rd_tag = '0;
        int_full = 1'b0; mult_full = 1'b0; div_full = 1'b0; ldst_full = 1'b0;
        br_resolve = 1'b0; flush = 1'b0;

        // Reset state
        chk_ready("ready_in_reset", 1'b0);
        step();
        @(negedge clk);
        chk("reset_strobes", {illegal, ldst_dispatch_en, div_dispatch_en,
                              mult_dispatch_en, int_dispatch_en}, 5'd0);
        chk("reset_d_opcode", d_opcode, 7'd0);
        chk("reset_d_rs2_data", d_rs2_data, 32'd0);
        chk("reset_d_rs1_valid", d_rs1_valid, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back ADD, MUL, DIVU, LW: one strobe per cycle
        k = cyc;
        offer(OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 32'h100, 7'h03, 7'h04, 6'd10);
        push(0, OP_R, 3'd0, 32'h22, 1'b1, 1'b1, 6'd10, 32'h100, 6'd3, k + 1);
        chk_ready("b2b_ready_add", 1'b1);
        step();
        offer(OP_R, 3'd0, 7'd1, 5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 32'h104, 7'h47, 7'h06, 6'd11);
        push(1, OP_R, 3'd0, 32'h44, 1'b0, 1'b1, 6'd11, 32'h104, 6'd7, k + 2);
        chk_ready("b2b_ready_mul", 1'b1);
        step();
        offer(OP_R, 3'd5, 7'd1, 5'd5, 5'd0, 32'h55, 32'h66, 32'h0, 32'h108, 7'h05, 7'h49, 6'd12);
        push(2, OP_R, 3'd5, 32'h66, 1'b1, 1'b1, 6'd12, 32'h108, 6'd5, k + 3);
        chk_ready("b2b_ready_div", 1'b1);
        step();
        offer(OP_LD, 3'd2, 7'd0, 5'd6, 5'd7, 32'h77, 32'h88, 32'h10, 32'h2000, 7'h02, 7'h48, 6'd13);
        push(3, OP_LD, 3'd2, 32'h88, 1'b1, 1'b1, 6'd13, 32'h2000, 6'd2, k + 4);
        chk_ready("b2b_ready_lw", 1'b1);
        step();
        in_valid = 1'b0;
        step();

        // ADDI x5,x0,0x7FF with pending rs1 tag on x0: immediate substituted
        k = cyc;
        offer(OP_I, 3'd0, 7'd0, 5'd0, 5'd9, 32'h0, 32'hDEAD, 32'h7FF, 32'h300, 7'h43, 7'h45, 6'd5);
        push(0, OP_I, 3'd0, 32'h7FF, 1'b1, 1'b1, 6'd5, 32'h300, 6'd3, k + 1);
        step();
        in_valid = 1'b0;
        step();

        // LW stalled 3 cycles by ldst_full; ADD waits behind it
        k = cyc;
        ldst_full = 1'b1;
        offer(OP_LD, 3'd2, 7'd0, 5'd1, 5'd0, 32'h1, 32'h55, 32'h4, 32'h4000, 7'h01, 7'h00, 6'd20);
        push(3, OP_LD, 3'd2, 32'h55, 1'b1, 1'b1, 6'd20, 32'h4000, 6'd1, k + 4);
        step();
        offer(OP_R, 3'd0, 7'd0, 5'd2, 5'd3, 32'h2, 32'h99, 32'h0, 32'h500, 7'h08, 7'h09, 6'd21);
        push(0, OP_R, 3'd0, 32'h99, 1'b1, 1'b1, 6'd21, 32'h500, 6'd8, k + 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", in_ready, 1'b0);
            chk("stall_d_opcode", d_opcode, OP_LD);
            chk("stall_d_rs2_data", d_rs2_data, 32'h55);
            chk("stall_d_imm", d_imm, 32'h4000);
            step();
        end
        ldst_full = 1'b0;
        chk_ready("stall_release_ready", 1'b1);
        step();
        in_valid = 1'b0;
        step();

        // BEQ then ADD; br_resolve five cycles after the BEQ strobe
        k = cyc;
        offer(OP_BR, 3'd0, 7'd0, 5'd1, 5'd2, 32'h1, 32'h12, 32'h8, 32'h600, 7'h0A, 7'h0B, 6'd0);
        push(0, OP_BR, 3'd0, 32'h12, 1'b1, 1'b1, 6'd0, 32'h600, 6'd10, k + 1);
        step();
        offer(OP_R, 3'd0, 7'd0, 5'd3, 5'd4, 32'h3, 32'h34, 32'h0, 32'h604, 7'h0C, 7'h0D, 6'd22);
        push(0, OP_R, 3'd0, 32'h34, 1'b1, 1'b1, 6'd22, 32'h604, 6'd12, k + 7);
        chk_ready("br_fire_ready", 1'b1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_ready("br_wait_ready", 1'b0);
            step();
        end
        br_resolve = 1'b1;
        chk_ready("br_resolve_ready", 1'b0);
        step();
        br_resolve = 1'b0;
        step();
        step();

        // BEQ dispatched, ADD held in BR_WAIT, then flushed
        k = cyc;
        offer(OP_BR, 3'd1, 7'd0, 5'd5, 5'd6, 32'h5, 32'h56, 32'h8, 32'h700, 7'h0E, 7'h0F, 6'd0);
        push(0, OP_BR, 3'd1, 32'h56, 1'b1, 1'b1, 6'd0, 32'h700, 6'd14, k + 1);
        step();
        offer(OP_R, 3'd0, 7'd0, 5'd7, 5'd8, 32'h7, 32'h78, 32'h0, 32'h704, 7'h10, 7'h11, 6'd23);
        step();
        in_valid = 1'b0;
        chk_ready("flush_pre_ready", 1'b0);
        step();
        flush = 1'b1;
        chk_ready("flush_ready", 1'b0);
        step();
        flush = 1'b0;
        offer(OP_R, 3'd0, 7'd0, 5'd9, 5'd10, 32'h9, 32'hA0, 32'h0, 32'h708, 7'h12, 7'h13, 6'd24);
        push(0, OP_R, 3'd0, 32'hA0, 1'b1, 1'b1, 6'd24, 32'h708, 6'd18, k + 5);
        chk_ready("post_flush_ready", 1'b1);
        step();
        in_valid = 1'b0;
        step();

        // Illegal opcode 0x7F with every queue full: pulse, no strobe
        k = cyc;
        int_full = 1'b1; mult_full = 1'b1; div_full = 1'b1; ldst_full = 1'b1;
        offer(7'h7F, 3'd1, 7'd0, 5'd0, 5'd0, 32'h0, 32'h77, 32'h0, 32'h800, 7'h04, 7'h00, 6'd30);
        push(4, 7'h7F, 3'd1, 32'h77, 1'b1, 1'b1, 6'd30, 32'h800, 6'd4, k + 1);
        step();
        in_valid = 1'b0;
        chk_ready("illegal_consume_ready", 1'b1);
        step();
        int_full = 1'b0; mult_full = 1'b0; div_full = 1'b0; ldst_full = 1'b0;
        step();

        // Reset in the middle of a stall
        int_full = 1'b1;
        offer(OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 32'h1, 32'hAB, 32'h0, 32'h900, 7'h01, 7'h02, 6'd31);
        step();
        in_valid = 1'b0;
        chk_ready("rst_stall_ready", 1'b0);
        step();
        rst_n = 1'b0;
        chk_ready("rst_low_ready", 1'b0);
        step();
        int_full = 1'b0;
        @(negedge clk);
        chk("rst_mid_strobes", {illegal, ldst_dispatch_en, div_dispatch_en,
                                mult_dispatch_en, int_dispatch_en}, 5'd0);
        chk("rst_mid_d_opcode", d_opcode, 7'd0);
        chk("rst_mid_d_rs2_data", d_rs2_data, 32'd0);
        chk("rst_mid_d_rd_tag", d_rd_tag, 6'd0);
        chk("rst_mid_d_imm", d_imm, 32'd0);
        chk("rst_mid_d_rs2_valid", d_rs2_valid, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
